// File: rtl/mul_seq_pkg.sv
// Shared ALU port definitions: data/op/shift widths and opcode map,
// used by both the ALU and the sequential multiplier.
package mul_seq_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned SH_W   = 4;

  localparam logic [OP_W-1:0] ALU_PASS = 3'b000;
  localparam logic [OP_W-1:0] ALU_ADD  = 3'b001;
  localparam logic [OP_W-1:0] ALU_SUB  = 3'b010;
  localparam logic [OP_W-1:0] ALU_SHR  = 3'b011;
  localparam logic [OP_W-1:0] ALU_SHL  = 3'b100;
  localparam logic [OP_W-1:0] ALU_NAND = 3'b101;
  localparam logic [OP_W-1:0] ALU_CMP  = 3'b110;
  localparam logic [OP_W-1:0] ALU_MAX  = 3'b111;

endpackage

// File: rtl/alu.sv
// Shared combinational 16-bit ALU; results and flags settle in the same cycle.
module alu
  import mul_seq_pkg::*;
(
  input  logic [DATA_W-1:0] Data1,
  input  logic [DATA_W-1:0] Data2,
  input  logic [OP_W-1:0]   operation,
  input  logic [SH_W-1:0]   shift_amount,
  output logic [DATA_W-1:0] Data_out,
  output logic              sign,
  output logic              zero,
  output logic              overflow,
  output logic              equal
);

  always_comb begin
    Data_out = '0;
    overflow = 1'b0;
    case (operation)
      ALU_PASS: Data_out = Data1;
      ALU_ADD: begin
        Data_out = Data1 + Data2;
        overflow = (Data1[15] == Data2[15]) && (Data_out[15] != Data1[15]);
      end
      ALU_SUB: begin
        Data_out = Data1 - Data2;
        overflow = (Data1[15] != Data2[15]) && (Data_out[15] != Data1[15]);
      end
      ALU_SHR:  Data_out = Data1 >> shift_amount;
      ALU_SHL:  Data_out = Data1 << shift_amount;
      ALU_NAND: Data_out = ~(Data1 & Data2);
      // Signed compare: 1 when Data1 < Data2
      ALU_CMP:  Data_out = {{(DATA_W-1){1'b0}}, ($signed(Data1) < $signed(Data2))};
      ALU_MAX:  Data_out = ($signed(Data1) > $signed(Data2)) ? Data1 : Data2;
      default:  Data_out = '0;
    endcase
  end

  assign sign  = Data_out[DATA_W-1];
  assign zero  = (Data_out == '0);
  assign equal = (Data1 == Data2);

endmodule

// File: rtl/mul_seq.sv
// Sequential unsigned 16x16 multiplier: shift-and-add driven through the
// shared ALU, one ALU operation per cycle, low 16 product bits returned.
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] Product,
  output logic              overflow,
  output logic              zero,
  output logic [DATA_W-1:0] alu_Data1,
  output logic [DATA_W-1:0] alu_Data2,
  output logic [OP_W-1:0]   alu_operation,
  output logic [SH_W-1:0]   alu_shift_amount,
  input  logic [DATA_W-1:0] alu_Data_out,
  input  logic              alu_sign,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_equal
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADD   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state, state_nx;
  logic [DATA_W-1:0] acc, acc_nx;
  logic [DATA_W-1:0] mcand, mcand_nx;
  logic [DATA_W-1:0] mplr, mplr_nx;
  logic              ovf, ovf_nx;

  // ALU flags are reserved; carry is derived locally from the add result
  logic unused_alu_flags;
  assign unused_alu_flags = alu_sign ^ alu_zero ^ alu_overflow ^ alu_equal;

  always_comb begin
    state_nx         = state;
    acc_nx           = acc;
    mcand_nx         = mcand;
    mplr_nx          = mplr;
    ovf_nx           = ovf;
    alu_operation    = ALU_PASS;
    alu_Data1        = '0;
    alu_Data2        = '0;
    alu_shift_amount = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          acc_nx   = '0;
          mcand_nx = A;
          mplr_nx  = B;
          ovf_nx   = 1'b0;
          if (B == '0)     state_nx = S_DONE;
          else if (B[0])   state_nx = S_ADD;
          else             state_nx = S_SHIFT;
        end
      end
      S_ADD: begin
        alu_operation = ALU_ADD;
        alu_Data1     = acc;
        alu_Data2     = mcand;
        acc_nx        = alu_Data_out;
        if (alu_Data_out < acc) ovf_nx = 1'b1;
        state_nx = (mplr[DATA_W-1:1] == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        alu_operation    = ALU_SHL;
        alu_Data1        = mcand;
        alu_shift_amount = 4'd1;
        mcand_nx         = alu_Data_out;
        mplr_nx          = mplr >> 1;
        // A set bit leaving mcand matters only if a later add will use it
        if (mcand[DATA_W-1] && (mplr[DATA_W-1:1] != '0)) ovf_nx = 1'b1;
        if (mplr_nx == '0)     state_nx = S_DONE;
        else if (mplr_nx[0])   state_nx = S_ADD;
        else                   state_nx = S_SHIFT;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplr     <= '0;
      ovf      <= 1'b0;
      Product  <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      mcand <= mcand_nx;
      mplr  <= mplr_nx;
      ovf   <= ovf_nx;
      // Result registers load on the edge entering DONE so they appear with done
      if ((state != S_DONE) && (state_nx == S_DONE)) begin
        Product  <= acc_nx;
        overflow <= ovf_nx;
        zero     <= (acc_nx == '0);
      end
    end
  end

  assign busy = (state == S_ADD) || (state == S_SHIFT);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq wired to the real ALU; compares against
// plain 32-bit arithmetic and a bit-count latency formula.
module tb_mul_seq;
  import mul_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        busy, done, overflow, zero;
  logic [15:0] Product;
  logic [15:0] alu_Data1, alu_Data2, alu_Data_out;
  logic [2:0]  alu_operation;
  logic [3:0]  alu_shift_amount;
  logic        alu_sign, alu_zero, alu_overflow, alu_equal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Product(Product), .overflow(overflow), .zero(zero),
    .alu_Data1(alu_Data1), .alu_Data2(alu_Data2), .alu_operation(alu_operation),
    .alu_shift_amount(alu_shift_amount), .alu_Data_out(alu_Data_out),
    .alu_sign(alu_sign), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_equal(alu_equal)
  );

  alu u_alu (
    .Data1(alu_Data1), .Data2(alu_Data2), .operation(alu_operation),
    .shift_amount(alu_shift_amount), .Data_out(alu_Data_out),
    .sign(alu_sign), .zero(alu_zero), .overflow(alu_overflow), .equal(alu_equal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Edges from the accepting edge to DONE: one per set bit (ADD) plus one
  // per position up to the top set bit (SHIFT).
  function automatic int exp_ops(input logic [15:0] b);
    int top = 0;
    if (b == 16'h0) return 0;
    for (int i = 0; i < 16; i++) if (b[i]) top = i;
    return $countones(b) + top;
  endfunction

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input bit interfere);
    logic [31:0] full;
    int n;
    full = {16'h0, a} * {16'h0, b};
    @(negedge clk);
    check("idle_alu_op", {29'h0, alu_operation}, 32'h0);
    check("idle_alu_d1", {16'h0, alu_Data1}, 32'h0);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      check("busy_during_op", {31'h0, busy}, 32'h1);
      if (interfere && n == 2) begin
        A = ~a; B = 16'h0003; start = 1'b1;
      end
      if (interfere && n == 4) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("done_seen", {31'h0, done}, 32'h1);
    check("latency", n, exp_ops(b));
    check("busy_in_done", {31'h0, busy}, 32'h0);
    check("product", {16'h0, Product}, full & 32'hFFFF);
    check("overflow", {31'h0, overflow}, {31'h0, (full > 32'hFFFF)});
    check("zero", {31'h0, zero}, {31'h0, (full[15:0] == 16'h0)});
    @(posedge clk); #1;
    check("done_one_cycle", {31'h0, done}, 32'h0);
    check("product_held", {16'h0, Product}, full & 32'hFFFF);
  endtask

  initial begin
    logic [15:0] ra, rb;
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_product", {16'h0, Product}, 32'h0);
    check("rst_zero", {31'h0, zero}, 32'h0);
    check("rst_alu_op", {29'h0, alu_operation}, 32'h0);
    #22 rst_n = 1'b1;

    run_mul(16'd3, 16'd5, 1'b0);
    run_mul(16'hFFFF, 16'h0001, 1'b0);
    run_mul(16'h1234, 16'h0000, 1'b0);
    run_mul(16'h0100, 16'h0100, 1'b0);
    run_mul(16'hFFFF, 16'hFFFF, 1'b0);
    run_mul(16'h0007, 16'hFFFF, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case (i % 4)
        0: rb = rb & 16'h00FF;
        1: ra = ra & 16'h00FF;
        default: ;
      endcase
      run_mul(ra, rb, (i % 5) == 0);
    end

    // Reset in the middle of the worst-case product
    @(negedge clk);
    A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_done", {31'h0, done}, 32'h0);
    check("midrst_product", {16'h0, Product}, 32'h0);
    check("midrst_ovf", {31'h0, overflow}, 32'h0);
    check("midrst_zero", {31'h0, zero}, 32'h0);
    check("midrst_alu_op", {29'h0, alu_operation}, 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst_no_done", {31'h0, done}, 32'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", {31'h0, busy | done}, 32'h0);
    run_mul(16'd3, 16'd5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
